bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter for the DE0 seven-segment display path. It accepts an unsigned binary value on a start strobe and converts it with a multi-cycle double-dabble (shift-add-3) loop. It then holds one 4-bit BCD digit per display, each of which drives the digit input of a downstream seven-segment decoder. It also produces per-digit leading-zero blank flags and a saturation flag for values that do not fit in the display.

---
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle double-dabble binary to BCD converter for the seven-segment path
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [WIDTH-1:0]      iVALUE,
  input  logic                  iSTART,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic [DIGITS-1:0]     oBLANK,
  output logic                  oOVF
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} stateT;

  stateT          state;
  stateT          nextState;
  logic [WIDTH-1:0] binReg;
  logic [SW-1:0]  scratch;
  logic [SW-1:0]  adj;
  logic [CW-1:0]  cnt;
  logic           ovfPend;
  logic           zeroRun;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iSTART) nextState = SHIFT;
      SHIFT:   if (cnt == CW'(1)) nextState = FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oBUSY = (state != IDLE);
  end

  // Add-3 correction on every scratch digit before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      binReg  <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovfPend <= 1'b0;
      oBCD    <= '0;
      oOVF    <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            binReg  <= iVALUE;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            ovfPend <= (32'(iVALUE) > MAX);
          end
        end
        SHIFT: begin
          {scratch, binReg} <= {adj, binReg} << 1;
          cnt               <= cnt - CW'(1);
        end
        FINISH: begin
          oBCD  <= ovfPend ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
          oOVF  <= ovfPend;
          oDONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Units digit is never blanked so a zero value still shows "0"
  always_comb begin
    oBLANK  = '0;
    zeroRun = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeroRun   = zeroRun & (oBCD[4*i +: 4] == 4'h0);
      oBLANK[i] = zeroRun;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [13:0] iVALUE;
  logic        iSTART;
  logic        oBUSY;
  logic        oDONE;
  logic [15:0] oBCD;
  logic [3:0]  oBLANK;
  logic        oOVF;

  int nChecks = 0;
  int nFails  = 0;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iVALUE (iVALUE),
    .iSTART (iSTART),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oBCD   (oBCD),
    .oBLANK (oBLANK),
    .oOVF   (oOVF)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion; optional iSTART pulses with 777 at conversion cycles pulseA/pulseB
  task automatic doConvert(input string tag, input logic [13:0] v, input logic [15:0] expBcd,
                           input logic [3:0] expBlank, input logic expOvf,
                           input int pulseA, input int pulseB);
    int busyCnt;
    int doneCnt;
    int doneCyc;
    logic stable;
    logic [15:0] prevBcd;
    busyCnt = 0;
    doneCnt = 0;
    doneCyc = 0;
    stable  = 1'b1;
    @(negedge iCLK);
    prevBcd = oBCD;
    iVALUE  = v;
    iSTART  = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge iCLK);
      if (oBUSY) busyCnt++;
      if (oDONE) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = c;
        checkVal({tag, " bcd"}, 32'(oBCD), 32'(expBcd));
        checkVal({tag, " blank"}, 32'(oBLANK), 32'(expBlank));
        checkVal({tag, " ovf"}, 32'(oOVF), 32'(expOvf));
      end
      if (c < 16 && oBCD !== prevBcd) stable = 1'b0;
      if (c == pulseA || c == pulseB) begin
        iSTART = 1'b1;
        iVALUE = 14'd777;
      end else begin
        iSTART = 1'b0;
        iVALUE = 14'd1111;
      end
    end
    checkVal({tag, " busy cycles"}, 32'(busyCnt), 32'd15);
    checkVal({tag, " done count"}, 32'(doneCnt), 32'd1);
    checkVal({tag, " done latency"}, 32'(doneCyc), 32'd16);
    checkVal({tag, " held"}, 32'(stable), 32'd1);
  endtask

  initial begin
    int doneCnt;
    int doneIdx;
    int doneAt [3];
    logic [15:0] expB2b [3];
    iRST_N = 1'b0;
    iVALUE = '0;
    iSTART = 1'b0;
    #12;
    checkVal("reset busy", 32'(oBUSY), 32'd0);
    checkVal("reset done", 32'(oDONE), 32'd0);
    checkVal("reset ovf", 32'(oOVF), 32'd0);
    checkVal("reset bcd", 32'(oBCD), 32'h0);
    checkVal("reset blank", 32'(oBLANK), 32'b1110);
    @(negedge iCLK);
    iRST_N = 1'b1;

    doConvert("v1234", 14'd1234, 16'h1234, 4'b0000, 1'b0, 0, 0);
    doConvert("v0", 14'd0, 16'h0000, 4'b1110, 1'b0, 0, 0);
    doConvert("v305", 14'd305, 16'h0305, 4'b1000, 1'b0, 0, 0);
    doConvert("v9999", 14'd9999, 16'h9999, 4'b0000, 1'b0, 0, 0);
    doConvert("v10000", 14'd10000, 16'h9999, 4'b0000, 1'b1, 0, 0);
    doConvert("v16383", 14'd16383, 16'h9999, 4'b0000, 1'b1, 0, 0);
    doConvert("v42", 14'd42, 16'h0042, 4'b1100, 1'b0, 0, 0);
    doConvert("busyprot", 14'd4321, 16'h4321, 4'b0000, 1'b0, 3, 10);

    // Back-to-back with iSTART held high
    expB2b[0] = 16'h0001;
    expB2b[1] = 16'h0002;
    expB2b[2] = 16'h0003;
    doneCnt = 0;
    doneIdx = 0;
    doneAt[0] = 0;
    doneAt[1] = 0;
    doneAt[2] = 0;
    @(negedge iCLK);
    iVALUE = 14'd1;
    iSTART = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      @(negedge iCLK);
      if (oDONE) begin
        doneCnt++;
        if (doneIdx < 3) begin
          doneAt[doneIdx] = c;
          checkVal($sformatf("b2b bcd %0d", doneIdx), 32'(oBCD), 32'(expB2b[doneIdx]));
          doneIdx++;
        end
      end
      if (c == 1)  iVALUE = 14'd2;
      if (c == 17) iVALUE = 14'd3;
      if (c == 33) iVALUE = 14'd9;
      if (c == 48) iSTART = 1'b0;
    end
    checkVal("b2b done count", 32'(doneCnt), 32'd3);
    checkVal("b2b done0 cycle", 32'(doneAt[0]), 32'd16);
    checkVal("b2b done1 cycle", 32'(doneAt[1]), 32'd32);
    checkVal("b2b done2 cycle", 32'(doneAt[2]), 32'd48);

    // Reset in the middle of a conversion, after an overflowing result
    doConvert("preRst", 14'd10000, 16'h9999, 4'b0000, 1'b1, 0, 0);
    @(negedge iCLK);
    iVALUE = 14'd5678;
    iSTART = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
    end
    checkVal("mid busy", 32'(oBUSY), 32'd1);
    #2;
    iRST_N = 1'b0;
    #1;
    checkVal("rst busy", 32'(oBUSY), 32'd0);
    checkVal("rst done", 32'(oDONE), 32'd0);
    checkVal("rst ovf", 32'(oOVF), 32'd0);
    checkVal("rst bcd", 32'(oBCD), 32'h0);
    checkVal("rst blank", 32'(oBLANK), 32'b1110);
    @(negedge iCLK);
    iRST_N = 1'b1;
    doneCnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge iCLK);
      if (oDONE || oBUSY) doneCnt++;
    end
    checkVal("rst no done", 32'(doneCnt), 32'd0);
    doConvert("v5678", 14'd5678, 16'h5678, 4'b0000, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
